// File: rtl/xgmii_rx_align.sv
// XGMII receive lane aligner: moves a start character arriving in lane 4
// down to lane 0 so downstream logic only ever sees lane-0 starts.
// Define XGMII_RX_ALIGN_STATS_EN to build the statistics counters; without
// it the counter ports read zero and stats_clr is ignored.
module xgmii_rx_align #(
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 xgmii_rx_clk,
    input  logic                 sys_rst_n,
    input  logic [71:0]          xgmii_rxd,
    input  logic                 stats_clr,
    output logic [71:0]          dout,
    output logic                 dout_sof,
    output logic                 dout_eof,
    output logic                 shift_active,
    output logic                 ipg_err,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] shift_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam logic [71:0] IDLE_WORD = 72'hff_0707070707070707;

    typedef enum logic [1:0] {PASS, SHIFT, DROP} state_t;

    state_t      state, nxt_state;
    logic [3:0]  held_ctrl, nxt_held_ctrl;
    logic [31:0] held_data, nxt_held_data;
    logic [7:0]  in_ctrl;
    logic [63:0] in_data;
    logic        is_idle, is_s0, is_s4, ipg_event;
    logic [71:0] nxt_word, shifted_word, flush_word;
    logic [71:0] align_word;
    // flag vector order: {ipg, shift, eof, sof}
    logic [3:0]  align_flags, out_flags;

    function automatic logic has_sof(input logic [71:0] w);
        return w[64] && (w[7:0] == 8'hfb);
    endfunction

    function automatic logic has_ctrl_byte(input logic [71:0] w, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (w[64+k] && (w[8*k +: 8] == code)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign in_ctrl      = xgmii_rxd[71:64];
    assign in_data      = xgmii_rxd[63:0];
    assign is_idle      = (in_ctrl == 8'hff) && (in_data[7:0] == 8'h07);
    assign is_s0        = in_ctrl[0] && (in_data[7:0] == 8'hfb);
    assign is_s4        = in_ctrl[4] && (in_data[39:32] == 8'hfb) && !is_s0;
    assign shifted_word = {in_ctrl[3:0], held_ctrl, in_data[31:0], held_data};
    assign flush_word   = {4'hf, held_ctrl, 32'h07070707, held_data};

    // Next aligner state and the word it emits for the current input.
    always_comb begin
        nxt_state     = state;
        nxt_held_ctrl = held_ctrl;
        nxt_held_data = held_data;
        nxt_word      = xgmii_rxd;
        ipg_event     = 1'b0;
        case (state)
            PASS: begin
                if (is_s4) begin
                    nxt_held_ctrl = in_ctrl[7:4];
                    nxt_held_data = in_data[63:32];
                    nxt_word      = IDLE_WORD;
                    nxt_state     = SHIFT;
                end
            end
            SHIFT: begin
                if (is_idle) begin
                    nxt_word  = flush_word;
                    nxt_state = PASS;
                end else if (is_s0) begin
                    if (held_ctrl == 4'hf) begin
                        nxt_word  = xgmii_rxd;
                        nxt_state = PASS;
                    end else begin
                        nxt_word  = flush_word;
                        ipg_event = 1'b1;
                        nxt_state = DROP;
                    end
                end else begin
                    nxt_word      = shifted_word;
                    nxt_held_ctrl = in_ctrl[7:4];
                    nxt_held_data = in_data[63:32];
                end
            end
            DROP: begin
                nxt_word = IDLE_WORD;
                if (is_idle) nxt_state = PASS;
            end
            default: begin
                nxt_word  = IDLE_WORD;
                nxt_state = PASS;
            end
        endcase
    end

    // Aligner state, held half-word and the registered align stage.
    always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= PASS;
            held_ctrl   <= '0;
            held_data   <= '0;
            align_word  <= IDLE_WORD;
            align_flags <= '0;
        end else begin
            state       <= nxt_state;
            held_ctrl   <= nxt_held_ctrl;
            held_data   <= nxt_held_data;
            align_word  <= nxt_word;
            align_flags <= {ipg_event, nxt_state == SHIFT,
                            has_ctrl_byte(nxt_word, 8'hfd), has_sof(nxt_word)};
        end
    end

    generate
        if (PIPE_STAGES == 0) begin : g_no_pipe
            assign dout      = align_word;
            assign out_flags = align_flags;
        end else begin : g_pipe
            logic [71:0] pipe_word  [PIPE_STAGES];
            logic [3:0]  pipe_flags [PIPE_STAGES];

            // Extra output stages; flags travel with their word.
            always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                        pipe_word[i]  <= IDLE_WORD;
                        pipe_flags[i] <= '0;
                    end
                end else begin
                    pipe_word[0]  <= align_word;
                    pipe_flags[0] <= align_flags;
                    for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                        pipe_word[i]  <= pipe_word[i-1];
                        pipe_flags[i] <= pipe_flags[i-1];
                    end
                end
            end

            assign dout      = pipe_word[PIPE_STAGES-1];
            assign out_flags = pipe_flags[PIPE_STAGES-1];
        end
    endgenerate

    assign dout_sof     = out_flags[0];
    assign dout_eof     = out_flags[1];
    assign shift_active = out_flags[2];
    assign ipg_err      = out_flags[3];

`ifdef XGMII_RX_ALIGN_STATS_EN
    logic       shift_inc;
    logic [1:0] err_inc;

    // An S4 is accepted in PASS, or in SHIFT when it is not also an idle word.
    assign shift_inc = is_s4 && ((state == PASS) || ((state == SHIFT) && !is_idle));
    assign err_inc   = {1'b0, has_ctrl_byte(xgmii_rxd, 8'hfe)} + {1'b0, ipg_event};

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt <= '0;
            shift_cnt <= '0;
            err_cnt   <= '0;
        end else if (stats_clr) begin
            frame_cnt <= '0;
            shift_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            frame_cnt <= sat_add(frame_cnt, {1'b0, dout_sof});
            shift_cnt <= sat_add(shift_cnt, {1'b0, shift_inc});
            err_cnt   <= sat_add(err_cnt, err_inc);
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign frame_cnt = '0;
    assign shift_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_xgmii_rx_align.sv
// Bench for xgmii_rx_align: two instances (PIPE_STAGES=1/CNT_WIDTH=8 and
// PIPE_STAGES=0/CNT_WIDTH=32) share one stimulus stream; a lane-level
// reference model predicts every output word and the counters.
module tb_xgmii_rx_align;

    localparam logic [71:0] IDLE_W = 72'hff_0707070707070707;
`ifdef XGMII_RX_ALIGN_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        xgmii_rx_clk = 1'b0;
    logic        sys_rst_n;
    logic [71:0] xgmii_rxd;
    logic        stats_clr;

    logic [71:0] dout_a, dout_b;
    logic        sof_a, eof_a, sh_a, ipg_a;
    logic        sof_b, eof_b, sh_b, ipg_b;
    logic [7:0]  frame_a, shift_a, err_a;
    logic [31:0] frame_b, shift_b, err_b;

    always #5 xgmii_rx_clk = ~xgmii_rx_clk;

    xgmii_rx_align #(.PIPE_STAGES(1), .CNT_WIDTH(8)) u_dut_a (
        .xgmii_rx_clk(xgmii_rx_clk), .sys_rst_n(sys_rst_n), .xgmii_rxd(xgmii_rxd),
        .stats_clr(stats_clr), .dout(dout_a), .dout_sof(sof_a), .dout_eof(eof_a),
        .shift_active(sh_a), .ipg_err(ipg_a), .frame_cnt(frame_a),
        .shift_cnt(shift_a), .err_cnt(err_a)
    );

    xgmii_rx_align #(.PIPE_STAGES(0), .CNT_WIDTH(32)) u_dut_b (
        .xgmii_rx_clk(xgmii_rx_clk), .sys_rst_n(sys_rst_n), .xgmii_rxd(xgmii_rxd),
        .stats_clr(stats_clr), .dout(dout_b), .dout_sof(sof_b), .dout_eof(eof_b),
        .shift_active(sh_b), .ipg_err(ipg_b), .frame_cnt(frame_b),
        .shift_cnt(shift_b), .err_cnt(err_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [71:0] word;
        logic        sof;
        logic        eof;
        logic        sh;
        logic        ipg;
    } exp_t;

    exp_t        hist[$];
    int          mode;          // 0 passing through, 1 realigning, 2 discarding
    logic        carry_c[4];
    logic [7:0]  carry_b[4];
    int          n_frames, n_shifts, n_errs;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] exp_cnt(input int v, input int width);
        longint lim;
        lim = (longint'(1) << width) - 1;
        if (!STATS_EN) return '0;
        return (longint'(v) > lim) ? 72'(lim) : 72'(v);
    endfunction

    task automatic model_reset();
        exp_t r;
        r = '{word: IDLE_W, sof: 1'b0, eof: 1'b0, sh: 1'b0, ipg: 1'b0};
        hist.delete();
        hist.push_back(r);
        mode = 0;
        for (int k = 0; k < 4; k++) begin
            carry_c[k] = 1'b0;
            carry_b[k] = 8'h00;
        end
        n_frames = 0;
        n_shifts = 0;
        n_errs   = 0;
    endtask

    // Reference: works lane by lane; the output starts as all-idle lanes.
    task automatic model_step(input logic [71:0] w);
        logic       ci[8];
        logic [7:0] bi[8];
        logic       co[8];
        logic [7:0] bo[8];
        logic       idle, s0, s4, full;
        exp_t       e;
        for (int k = 0; k < 8; k++) begin
            ci[k] = w[64+k];
            bi[k] = w[8*k +: 8];
            co[k] = 1'b1;
            bo[k] = 8'h07;
        end
        idle = (bi[0] == 8'h07);
        for (int k = 0; k < 8; k++) if (!ci[k]) idle = 1'b0;
        s0 = ci[0] && (bi[0] == 8'hfb);
        s4 = ci[4] && (bi[4] == 8'hfb) && !s0;
        for (int k = 0; k < 8; k++) if (ci[k] && (bi[k] == 8'hfe)) begin
            n_errs++;
            break;
        end
        e.ipg = 1'b0;
        if (mode == 0) begin
            if (s4) begin
                for (int k = 0; k < 4; k++) begin
                    carry_c[k] = ci[k+4];
                    carry_b[k] = bi[k+4];
                end
                mode = 1;
                n_shifts++;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    co[k] = ci[k];
                    bo[k] = bi[k];
                end
            end
        end else if (mode == 1) begin
            full = carry_c[0] && carry_c[1] && carry_c[2] && carry_c[3];
            if (idle) begin
                for (int k = 0; k < 4; k++) begin
                    co[k] = carry_c[k];
                    bo[k] = carry_b[k];
                end
                mode = 0;
            end else if (s0 && full) begin
                for (int k = 0; k < 8; k++) begin
                    co[k] = ci[k];
                    bo[k] = bi[k];
                end
                mode = 0;
            end else if (s0) begin
                for (int k = 0; k < 4; k++) begin
                    co[k] = carry_c[k];
                    bo[k] = carry_b[k];
                end
                e.ipg = 1'b1;
                n_errs++;
                mode = 2;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    co[k]      = carry_c[k];
                    bo[k]      = carry_b[k];
                    co[k+4]    = ci[k];
                    bo[k+4]    = bi[k];
                    carry_c[k] = ci[k+4];
                    carry_b[k] = bi[k+4];
                end
                if (s4) n_shifts++;
            end
        end else begin
            if (idle) mode = 0;
        end
        e.eof = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e.word[64+k]    = co[k];
            e.word[8*k +: 8] = bo[k];
            if (co[k] && (bo[k] == 8'hfd)) e.eof = 1'b1;
        end
        e.sof = co[0] && (bo[0] == 8'hfb);
        e.sh  = (mode == 1);
        if (e.sof) n_frames++;
        hist.push_back(e);
        if (hist.size() > 2) hist.delete(0);
    endtask

    // Drive one word at a falling edge; check both instances at the next one.
    task automatic send(input logic [71:0] w);
        exp_t ea, eb;
        model_step(w);
        xgmii_rxd = w;
        @(negedge xgmii_rx_clk);
        ea = hist[hist.size()-2];
        eb = hist[hist.size()-1];
        chk("dout_a", dout_a, ea.word);
        chk("sof_a", 72'(sof_a), 72'(ea.sof));
        chk("eof_a", 72'(eof_a), 72'(ea.eof));
        chk("shift_active_a", 72'(sh_a), 72'(ea.sh));
        chk("ipg_err_a", 72'(ipg_a), 72'(ea.ipg));
        chk("dout_b", dout_b, eb.word);
        chk("sof_b", 72'(sof_b), 72'(eb.sof));
        chk("eof_b", 72'(eof_b), 72'(eb.eof));
        chk("shift_active_b", 72'(sh_b), 72'(eb.sh));
        chk("ipg_err_b", 72'(ipg_b), 72'(eb.ipg));
    endtask

    task automatic check_counters();
        chk("frame_cnt_a", 72'(frame_a), exp_cnt(n_frames, 8));
        chk("shift_cnt_a", 72'(shift_a), exp_cnt(n_shifts, 8));
        chk("err_cnt_a",   72'(err_a),   exp_cnt(n_errs, 8));
        chk("frame_cnt_b", 72'(frame_b), exp_cnt(n_frames, 32));
        chk("shift_cnt_b", 72'(shift_b), exp_cnt(n_shifts, 32));
        chk("err_cnt_b",   72'(err_b),   exp_cnt(n_errs, 32));
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) send(IDLE_W);
    endtask

    task automatic clear_stats();
        stats_clr = 1'b1;
        send(IDLE_W);
        stats_clr = 1'b0;
        n_frames = 0;
        n_shifts = 0;
        n_errs   = 0;
    endtask

    function automatic logic [71:0] s0_w();
        return {8'h01, 64'hd5555555555555fb};
    endfunction

    function automatic logic [71:0] s4_w();
        return {8'h1f, 64'h555555fb_07070707};
    endfunction

    function automatic logic [71:0] data_w();
        return {8'h00, $urandom(), $urandom()};
    endfunction

    function automatic logic [71:0] term_w(input int t);
        logic [71:0] w;
        w = data_w();
        for (int k = 0; k < 8; k++) begin
            if (k == t) begin
                w[64+k]    = 1'b1;
                w[8*k +: 8] = 8'hfd;
            end else if (k > t) begin
                w[64+k]    = 1'b1;
                w[8*k +: 8] = 8'h07;
            end
        end
        return w;
    endfunction

    function automatic logic [71:0] junk_w();
        logic [71:0] w;
        logic [7:0]  codes[4];
        codes[0] = 8'h07; codes[1] = 8'hfb; codes[2] = 8'hfd; codes[3] = 8'hfe;
        w = data_w();
        w[71:64] = 8'($urandom());
        for (int k = 0; k < 8; k++) begin
            int r;
            r = int'($urandom_range(0, 5));
            if (r < 4) w[8*k +: 8] = codes[r];
        end
        return w;
    endfunction

    task automatic frame(input bit lane4, input int ndata, input int t);
        send(lane4 ? s4_w() : s0_w());
        for (int i = 0; i < ndata; i++) send(data_w());
        send(term_w(t));
    endtask

    initial begin
        sys_rst_n = 1'b0;
        stats_clr = 1'b0;
        xgmii_rxd = IDLE_W;
        model_reset();
        repeat (3) @(negedge xgmii_rx_clk);
        chk("reset_dout_a", dout_a, IDLE_W);
        chk("reset_dout_b", dout_b, IDLE_W);
        chk("reset_flags_a", 72'({sof_a, eof_a, sh_a, ipg_a}), 72'(0));
        chk("reset_flags_b", 72'({sof_b, eof_b, sh_b, ipg_b}), 72'(0));
        check_counters();
        sys_rst_n = 1'b1;

        // Lane-0 frame passes through unchanged.
        frame(1'b0, 3, 2);
        idles(3);
        check_counters();

        // Lane-4 frame, terminate in byte 1 of the following word.
        frame(1'b1, 0, 1);
        idles(3);
        check_counters();

        // Two shifted frames back to back.
        frame(1'b1, 1, 6);
        frame(1'b1, 1, 3);
        idles(3);
        check_counters();

        // S0 arrives while held half carries data.
        clear_stats();
        send(s4_w());
        send(data_w());
        send(data_w());
        send(s0_w());
        send(data_w());
        send(data_w());
        idles(3);
        check_counters();

        // Saturation at 255 and clear coinciding with a start word.
        clear_stats();
        for (int i = 0; i < 300; i++) begin
            frame(1'b0, 1, int'($urandom_range(0, 7)));
            send(IDLE_W);
        end
        idles(2);
        check_counters();
        send(s0_w());
        send(data_w());
        check_counters();
        stats_clr = 1'b1;
        send(term_w(3));
        stats_clr = 1'b0;
        n_frames = 0;
        n_shifts = 0;
        n_errs   = 0;
        check_counters();
        idles(3);
        check_counters();

        // Asynchronous reset in the middle of a shifted frame.
        send(s4_w());
        send(data_w());
        send(data_w());
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_rst_dout_a", dout_a, IDLE_W);
        chk("async_rst_shift_a", 72'(sh_a), 72'(0));
        chk("async_rst_dout_b", dout_b, IDLE_W);
        chk("async_rst_shift_b", 72'(sh_b), 72'(0));
        xgmii_rxd = IDLE_W;
        repeat (2) @(negedge xgmii_rx_clk);
        sys_rst_n = 1'b1;
        model_reset();
        send(data_w());
        send(term_w(5));
        idles(3);
        check_counters();

        // Randomized traffic mix.
        clear_stats();
        for (int seg = 0; seg < 400; seg++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind <= 3) begin
                frame(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
                idles(int'($urandom_range(0, 2)));
            end else if (kind <= 6) begin
                frame(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
                idles(int'($urandom_range(0, 2)));
            end else if (kind == 7) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) send(junk_w());
            end else if (kind == 8) begin
                idles(int'($urandom_range(1, 3)));
            end else begin
                send(s0_w());
            end
            if ((seg % 40) == 39) begin
                idles(4);
                check_counters();
            end
        end
        idles(4);
        check_counters();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
